// File: rtl/pipe_mem_ctrl.sv
// pipe_mem_ctrl: pipeline sequencer and unified-memory arbiter for the 5-stage core.
//
// Owns the single RAM port shared by instruction fetch (IF) and load/store (MEM),
// generates the stall vector for PC/IF_ID/ID_EX/EX_MEM/MEM_WB, and drops a fetch
// that was in flight when EX resolved a taken branch.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ack) and address
//   if_ack/if_rdata          one-cycle fetch completion and fetched word
//   mem_req/mem_we/mem_addr/mem_wdata/mem_sel
//                            MEM-stage access (held until mem_ack)
//   mem_ack/mem_rdata        one-cycle access completion and load data
//   id_stall_req             load-use hazard from ID
//   ex_b_flag                taken branch/jump resolved in EX
//   ram_req/ram_we/ram_addr/ram_wdata/ram_sel
//                            latched RAM request, held until ram_ack
//   ram_ack/ram_rdata        one-cycle RAM completion and read data
//   stall[5:0]               hold: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
//   bus_err                  one-cycle pulse on watchdog abort
//
// Optional feature: define PIPE_CTRL_WDOG_EN to abort a transaction that has
// waited 255 busy cycles without ram_ack. Without it bus_err is tied to 0.
module pipe_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    input  logic        id_stall_req,
    input  logic        ex_b_flag,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_sel,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata,
    output logic [5:0]  stall,
    output logic        bus_err
);

    typedef enum logic [1:0] {StIdle, StIfBusy, StMemBusy} state_e;

    state_e      state_q, state_d;
    logic        discard_q, discard_d;
    logic        ram_req_q, ram_req_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [3:0]  ram_sel_q, ram_sel_d;
    logic        wdog_abort;
    logic        done;

`ifdef PIPE_CTRL_WDOG_EN
    logic [7:0] wdog_q, wdog_d;

    // Counter sits at 0 in IDLE, so it is clear on the first busy cycle after a grant.
    assign wdog_d     = (state_q == StIdle) ? 8'd0 : wdog_q + 8'd1;
    assign wdog_abort = (state_q != StIdle) && (wdog_q == 8'hFF) && !ram_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_abort = 1'b0;
`endif

    // A busy transaction ends on the RAM ack or on a watchdog abort.
    assign done = (state_q != StIdle) && (ram_ack || wdog_abort);

    // Completion outputs are combinational so the requester sees them in the ack cycle.
    always_comb begin
        if_ack    = !rst && (state_q == StIfBusy) && done && !(discard_q || ex_b_flag);
        if_rdata  = (if_ack && ram_ack) ? ram_rdata : 32'd0;
        mem_ack   = !rst && (state_q == StMemBusy) && done;
        mem_rdata = (mem_ack && ram_ack) ? ram_rdata : 32'd0;
        bus_err   = !rst && wdog_abort;
    end

    // Stall priority: MEM access freezes everything up to MEM (bubble into WB),
    // load-use freezes PC..ID, a pending fetch freezes PC and IF.
    always_comb begin
        stall = 6'b000000;
        if (rst) begin
            stall = 6'b000000;
        end else if (mem_req && !mem_ack) begin
            stall = 6'b011111;
        end else if (id_stall_req) begin
            stall = 6'b000111;
        end else if (if_req && !if_ack) begin
            stall = 6'b000011;
        end
    end

    always_comb begin
        state_d     = state_q;
        discard_d   = discard_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_sel_d   = ram_sel_q;
        unique case (state_q)
            StIdle: begin
                // A stray ram_ack here is ignored.
                if (mem_req) begin
                    state_d     = StMemBusy;
                    ram_req_d   = 1'b1;
                    ram_we_d    = mem_we;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    ram_sel_d   = mem_sel;
                end else if (if_req) begin
                    state_d     = StIfBusy;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = 32'd0;
                    ram_sel_d   = 4'hF;
                end
            end
            StIfBusy: begin
                if (done) begin
                    state_d   = StIdle;
                    ram_req_d = 1'b0;
                    discard_d = 1'b0;
                end else if (ex_b_flag) begin
                    // Word in flight is on the wrong path; drop it when it arrives.
                    discard_d = 1'b1;
                end
            end
            StMemBusy: begin
                if (done) begin
                    state_d   = StIdle;
                    ram_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = StIdle;
                ram_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            discard_q   <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_wdata_q <= 32'd0;
            ram_sel_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            discard_q   <= discard_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_sel_q   <= ram_sel_d;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_sel   = ram_sel_q;

endmodule
